// File: rtl/imem_arbiter.sv
// imem_arbiter: two-master arbiter in front of a single-port instruction memory.
//   A fetch master (f_*) and a loader master (l_*) share one synchronous memory
//   port (m_*). Fetch has priority unless the loader has been starved for
//   MAX_WAIT consecutive cycles, or the loader holds the memory locked.
//   Faulting addresses (misaligned or beyond the AW-bit word space) are granted
//   but never reach memory; they complete one cycle later with an error/zero.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   f_req, f_addr                 fetch request / byte address
//   f_gnt, f_rvalid, f_rdata, f_err   fetch grant and response
//   l_req, l_we, l_lock, l_addr, l_wdata   loader request
//   l_gnt, l_rvalid, l_rdata      loader grant and response
//   m_en, m_we, m_addr, m_wdata, m_rdata   memory port (1-cycle read latency)
module imem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);

  localparam logic SHARED = 1'b0;
  localparam logic LOCKED = 1'b1;

  logic          state;
  logic [CW-1:0] wait_cnt;

  // Response tag for the grant issued in the previous cycle.
  logic rsp_f;
  logic rsp_l;
  logic rsp_flt;
  logic rsp_we;

  logic        gnt_f;
  logic        gnt_l;
  logic        starved;
  logic [31:0] addr;
  logic        fault;
  logic        access;

  always_comb begin
    gnt_f   = 1'b0;
    gnt_l   = 1'b0;
    starved = l_req && (wait_cnt == CW'(MAX_WAIT));
    if (!rst) begin
      if (state == LOCKED) begin
        gnt_l = l_req;
      end else begin
        gnt_l = l_req && (!f_req || starved);
        gnt_f = f_req && !gnt_l;
      end
    end
  end

  assign addr   = gnt_l ? l_addr : f_addr;
  assign fault  = (addr[1:0] != 2'b00) || ((addr >> (AW + 2)) != '0);
  assign access = (gnt_f || gnt_l) && !fault;

  assign f_gnt   = gnt_f;
  assign l_gnt   = gnt_l;
  assign m_en    = access;
  assign m_we    = access && gnt_l && l_we;
  assign m_addr  = access ? addr[AW+1:2] : '0;
  assign m_wdata = (access && gnt_l && l_we) ? l_wdata : '0;

  // Tags clear synchronously, so the rst term here hides a response that was
  // already pending on the cycle reset is first sampled.
  assign f_rvalid = rsp_f && !rst;
  assign f_err    = rsp_f && rsp_flt && !rst;
  assign f_rdata  = (rsp_f && !rsp_flt && !rst) ? m_rdata : '0;
  assign l_rvalid = rsp_l && !rst;
  assign l_rdata  = (rsp_l && !rsp_flt && !rsp_we && !rst) ? m_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SHARED;
      wait_cnt <= '0;
      rsp_f    <= 1'b0;
      rsp_l    <= 1'b0;
      rsp_flt  <= 1'b0;
      rsp_we   <= 1'b0;
    end else begin
      rsp_f   <= gnt_f;
      rsp_l   <= gnt_l;
      rsp_flt <= fault && (gnt_f || gnt_l);
      rsp_we  <= gnt_l && l_we;

      case (state)
        SHARED:  if (gnt_l && l_lock) state <= LOCKED;
        LOCKED:  if (!l_req || !l_lock) state <= SHARED;
        default: state <= SHARED;
      endcase

      if (gnt_l) begin
        wait_cnt <= '0;
      end else if (l_req && (wait_cnt != CW'(MAX_WAIT))) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed stimulus for imem_arbiter with a transaction-level
// reference model (grant rules, byte-address arithmetic, response queue and a
// shadow memory) compared against every DUT output once per cycle, plus
// hand-computed literal expectations for the key scenarios.
module tb_imem_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int AW        = 8;
  localparam int MEM_WORDS = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_req = 1'b0;
  logic [31:0]   f_addr = '0;
  logic          f_gnt, f_rvalid, f_err;
  logic [31:0]   f_rdata;
  logic          l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
  logic [31:0]   l_addr = '0, l_wdata = '0;
  logic          l_gnt, l_rvalid;
  logic [31:0]   l_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  imem_arbiter #(.MAX_WAIT(MAX_WAIT), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr),
    .l_wdata(l_wdata), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: read data appears the cycle after m_en.
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      m_rdata <= mem[m_addr];
    end
  end

  function automatic void chk1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk32(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    bit          to_loader;
    bit          flt;
    logic [31:0] data;
  } rsp_t;

  rsp_t rsp_q[$];
  bit   md_locked = 0;
  int   md_wait   = 0;

  task automatic model_step();
    bit          eg_l, eg_f, flt, acc, wr, have;
    logic [31:0] a;
    rsp_t        cur, nxt;
    if (rst) begin
      rsp_q.delete();
      md_locked = 0;
      md_wait   = 0;
      chk1("rst_f_gnt", f_gnt, 1'b0);
      chk1("rst_l_gnt", l_gnt, 1'b0);
      chk1("rst_m_en", m_en, 1'b0);
      chk1("rst_m_we", m_we, 1'b0);
      chk32("rst_m_addr", 32'(m_addr), '0);
      chk32("rst_m_wdata", m_wdata, '0);
      chk1("rst_f_rvalid", f_rvalid, 1'b0);
      chk1("rst_f_err", f_err, 1'b0);
      chk32("rst_f_rdata", f_rdata, '0);
      chk1("rst_l_rvalid", l_rvalid, 1'b0);
      chk32("rst_l_rdata", l_rdata, '0);
      return;
    end
    eg_l = l_req && (md_locked || md_wait >= MAX_WAIT || !f_req);
    eg_f = f_req && !md_locked && !eg_l;
    a    = eg_l ? l_addr : f_addr;
    flt  = (a % 4 != 0) || (a >= 32'(4 * MEM_WORDS));
    acc  = (eg_l || eg_f) && !flt;
    wr   = acc && eg_l && l_we;
    have = rsp_q.size() > 0;
    if (have) cur = rsp_q.pop_front();
    else cur = '{to_loader: 0, flt: 0, data: '0};

    chk1("f_gnt", f_gnt, eg_f);
    chk1("l_gnt", l_gnt, eg_l);
    chk1("m_en", m_en, acc);
    chk1("m_we", m_we, wr);
    chk32("m_addr", 32'(m_addr), acc ? a / 4 : 32'd0);
    chk32("m_wdata", m_wdata, wr ? l_wdata : 32'd0);
    chk1("f_rvalid", f_rvalid, have && !cur.to_loader);
    chk1("f_err", f_err, have && !cur.to_loader && cur.flt);
    chk32("f_rdata", f_rdata, (have && !cur.to_loader) ? cur.data : 32'd0);
    chk1("l_rvalid", l_rvalid, have && cur.to_loader);
    chk32("l_rdata", l_rdata, (have && cur.to_loader) ? cur.data : 32'd0);

    if (eg_l || eg_f) begin
      nxt.to_loader = eg_l;
      nxt.flt       = flt;
      nxt.data      = (acc && !wr) ? ref_mem[a[9:2]] : 32'd0;
      rsp_q.push_back(nxt);
    end
    if (wr) ref_mem[a[9:2]] = l_wdata;

    if (md_locked) begin
      if (!l_req || !l_lock) md_locked = 0;
    end else if (eg_l && l_lock) begin
      md_locked = 1;
    end
    if (eg_l) md_wait = 0;
    else if (l_req && md_wait < MAX_WAIT) md_wait++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic fr, input logic [31:0] fa,
                       input logic lr, input logic lwe, input logic llk,
                       input logic [31:0] la, input logic [31:0] lwd);
    @(negedge clk);
    rst = r; f_req = fr; f_addr = fa;
    l_req = lr; l_we = lwe; l_lock = llk; l_addr = la; l_wdata = lwd;
    #4;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0, 0, '0, '0);
  endtask

  initial begin
    int  n;
    bit  got;
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem[i]     = 32'(i) * 32'h01010101 + 32'h11;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h00000013; ref_mem[0] = 32'h00000013;
    mem[1] = 32'h00500093; ref_mem[1] = 32'h00500093;

    // Reset with requests present: they must be ignored.
    drive(1, 1, 32'h4, 1, 0, 0, 32'h0, '0);
    chk1("lit_rst_f_gnt", f_gnt, 1'b0);
    chk1("lit_rst_l_gnt", l_gnt, 1'b0);
    drive(1, 1, 32'h4, 1, 0, 0, 32'h0, '0);
    idle();

    // Single fetch of word 1.
    drive(0, 1, 32'h4, 0, 0, 0, '0, '0);
    chk1("lit_fetch_gnt", f_gnt, 1'b1);
    chk32("lit_fetch_maddr", 32'(m_addr), 32'd1);
    idle();
    chk1("lit_fetch_rvalid", f_rvalid, 1'b1);
    chk32("lit_fetch_rdata", f_rdata, 32'h00500093);
    chk1("lit_fetch_err", f_err, 1'b0);

    // Starvation: fetch wins 4 cycles, loader forced in the 5th.
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 32'h8, 1, 0, 0, 32'h10, '0);
      chk1($sformatf("lit_starve_f%0d", i), f_gnt, i != 4);
      chk1($sformatf("lit_starve_l%0d", i), l_gnt, i == 4);
    end
    drive(0, 0, '0, 1, 0, 0, 32'h10, '0);
    chk1("lit_starve_drain", l_gnt, 1'b1);
    idle();

    // Locked write at 0x8 competing with fetch.
    n = 0; got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      drive(0, 1, 32'h4, 1, 1, 1, 32'h8, 32'hDEADBEEF);
      n++;
      if (l_gnt) begin
        got = 1;
        chk1("lit_lock_mwe", m_we, 1'b1);
        chk32("lit_lock_maddr", 32'(m_addr), 32'd2);
        chk32("lit_lock_mwdata", m_wdata, 32'hDEADBEEF);
      end
    end
    chk32("lit_lock_latency", 32'(n), 32'd5);
    drive(0, 1, 32'h4, 1, 0, 1, 32'h8, '0);
    chk1("lit_locked_f_gnt", f_gnt, 1'b0);
    chk1("lit_locked_l_gnt", l_gnt, 1'b1);
    chk1("lit_wr_ack", l_rvalid, 1'b1);
    chk32("lit_wr_ack_data", l_rdata, 32'h0);
    drive(0, 1, 32'h4, 1, 0, 0, 32'h8, '0);
    chk1("lit_unlock_l_gnt", l_gnt, 1'b1);
    chk32("lit_locked_rdata", l_rdata, 32'hDEADBEEF);
    drive(0, 1, 32'h4, 0, 0, 0, '0, '0);
    chk1("lit_unlocked_f_gnt", f_gnt, 1'b1);
    idle();

    // Faulting fetches.
    drive(0, 1, 32'h6, 0, 0, 0, '0, '0);
    chk1("lit_mis_gnt", f_gnt, 1'b1);
    chk1("lit_mis_men", m_en, 1'b0);
    drive(0, 1, 32'h400, 0, 0, 0, '0, '0);
    chk1("lit_oob_gnt", f_gnt, 1'b1);
    chk1("lit_oob_men", m_en, 1'b0);
    chk1("lit_mis_err", f_err, 1'b1);
    chk32("lit_mis_rdata", f_rdata, 32'h0);
    idle();
    chk1("lit_oob_rvalid", f_rvalid, 1'b1);
    chk1("lit_oob_err", f_err, 1'b1);

    // Faulting loader write must not touch memory.
    drive(0, 0, '0, 1, 1, 0, 32'h3, 32'h12345678);
    chk1("lit_lwfault_gnt", l_gnt, 1'b1);
    chk1("lit_lwfault_mwe", m_we, 1'b0);
    drive(0, 0, '0, 1, 0, 0, 32'h0, '0);
    chk1("lit_lwfault_rvalid", l_rvalid, 1'b1);
    chk32("lit_lwfault_rdata", l_rdata, 32'h0);
    idle();
    chk32("lit_word0_rdata", l_rdata, 32'h00000013);

    // Reset right after a fetch grant drops the pending response.
    drive(0, 1, 32'h4, 0, 0, 0, '0, '0);
    drive(1, 1, 32'h4, 1, 0, 0, '0, '0);
    chk1("lit_rst_drop_rvalid", f_rvalid, 1'b0);
    chk1("lit_rst_drop_gnt", f_gnt, 1'b0);
    idle();
    chk1("lit_rst_after_rvalid", f_rvalid, 1'b0);

    // Reset from LOCKED returns to SHARED: fetch wins again.
    drive(0, 0, '0, 1, 0, 1, 32'h0, '0);
    drive(1, 0, '0, 1, 0, 1, 32'h0, '0);
    drive(0, 1, 32'h4, 1, 0, 1, 32'h0, '0);
    chk1("lit_rst_shared_f", f_gnt, 1'b1);
    chk1("lit_rst_shared_l", l_gnt, 1'b0);
    idle();

    // Alternating loader read at 0x0 and fetch at 0x4.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) drive(0, 0, '0, 1, 0, 0, 32'h0, '0);
      else            drive(0, 1, 32'h4, 0, 0, 0, '0, '0);
      if (i > 0) begin
        chk1($sformatf("lit_alt_lrv%0d", i), l_rvalid, i % 2 == 1);
        chk1($sformatf("lit_alt_frv%0d", i), f_rvalid, i % 2 == 0);
      end
    end
    idle();
    chk32("lit_alt_last", f_rdata, 32'h00500093);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
